// File: rtl/tff_bank_ctrl_if.sv
// Control/status and bank-side signals of the TFF bank sequencer.
// master: software strobes plus the bank's Q readback; slave: the sequencer.
interface tff_bank_ctrl_if #(parameter int WIDTH = 4);
  logic             start;
  logic             stop;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clear;
  logic [WIDTH-1:0] modulo;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] t_out;
  logic             bank_clr;
  logic             busy;
  logic             tc;
  logic             err;
  logic [1:0]       state;

  modport master (
    output start, stop, up, load, load_val, clear, modulo, q_fb,
    input  t_out, bank_clr, busy, tc, err, state
  );

  modport slave (
    input  start, stop, up, load, load_val, clear, modulo, q_fb,
    output t_out, bank_clr, busy, tc, err, state
  );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequencer turning a bank of T flip-flops into a modulo up/down counter
// with run/stop, parallel load, clear and a shadow-count integrity check.
module tff_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  tff_bank_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_LOAD  = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  state_t           st, st_nx;
  logic             ret_run, ret_run_nx;
  logic [WIDTH-1:0] shadow, load_r;
  logic [WIDTH-1:0] q, inc_t, dec_t, t_cnt;
  logic             wrap, tc_r, err_r, ctl_st;

  assign q      = bus.q_fb;
  assign ctl_st = (st == S_IDLE) || (st == S_RUN);

  // Bit i toggles when all lower bits are 1 (increment) or all 0 (decrement).
  assign inc_t[0] = 1'b1;
  assign dec_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_tog
    assign inc_t[i] = inc_t[i-1] &  q[i-1];
    assign dec_t[i] = dec_t[i-1] & ~q[i-1];
  end

  // Toggle mask for one RUN cycle; out-of-range counts snap back into 0..M.
  always_comb begin
    t_cnt = inc_t;
    wrap  = 1'b0;
    if (bus.up) begin
      if (q >= bus.modulo) begin
        t_cnt = q;
        wrap  = 1'b1;
      end
    end else if (q == '0) begin
      t_cnt = bus.modulo;
      wrap  = 1'b1;
    end else if (q > bus.modulo) begin
      t_cnt = q ^ bus.modulo;
    end else begin
      t_cnt = dec_t;
    end
  end

  always_comb begin
    bus.t_out    = '0;
    bus.bank_clr = 1'b0;
    if (!reset_n) begin
      bus.bank_clr = 1'b1;
    end else begin
      case (st)
        S_RUN:   bus.t_out    = t_cnt;
        S_LOAD:  bus.t_out    = q ^ load_r;
        S_CLEAR: bus.bank_clr = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nx      = st;
    ret_run_nx = ret_run;
    case (st)
      S_IDLE, S_RUN: begin
        if (bus.clear) begin
          st_nx      = S_CLEAR;
          ret_run_nx = (st == S_RUN);
        end else if (bus.load) begin
          st_nx      = S_LOAD;
          ret_run_nx = (st == S_RUN);
        end else if (bus.stop && st == S_RUN) begin
          st_nx = S_IDLE;
        end else if (bus.start && st == S_IDLE) begin
          st_nx = S_RUN;
        end
      end
      default: st_nx = ret_run ? S_RUN : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= S_IDLE;
      ret_run <= 1'b0;
      shadow  <= '0;
      load_r  <= '0;
      tc_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      st      <= st_nx;
      ret_run <= ret_run_nx;
      tc_r    <= (st == S_RUN) && wrap;
      // Capture on the strobe so the LOAD cycle does not depend on load_val holding.
      if (ctl_st && bus.load)
        load_r <= bus.load_val;
      case (st)
        S_RUN:   shadow <= q ^ t_cnt;
        S_LOAD:  shadow <= load_r;
        S_CLEAR: shadow <= '0;
        default: ;
      endcase
      if (st == S_CLEAR)
        err_r <= 1'b0;
      else if (ctl_st && (q != shadow))
        err_r <= 1'b1;
    end
  end

  assign bus.busy  = (st == S_RUN);
  assign bus.tc    = tc_r;
  assign bus.err   = err_r;
  assign bus.state = st;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Self-checking bench: behavioural TFF bank plus a count-level reference model.
module tb_tff_bank_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] bq;
  logic [W-1:0] inj;
  int           checks = 0;
  int           errors = 0;

  // Reference model: expected count, shadow, state code, flags.
  int mq, msh, ms, mret, mload;
  bit mtc, merr;

  tff_bank_ctrl_if #(.WIDTH(W)) bus();
  tff_bank_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // The controlled bank: async clear, toggle per T bit; inj models an upset.
  assign bus.q_fb = bq;
  always @(posedge clk or posedge bus.bank_clr)
    if (bus.bank_clr) bq <= '0;
    else              bq <= bq ^ bus.t_out ^ inj;

  task automatic model_reset();
    mq = 0; msh = 0; ms = 0; mret = 0; mload = 0; mtc = 0; merr = 0;
  endtask

  // Advance one clock: predict from the inputs present at the edge, then land on negedge.
  task automatic tick();
    int nq, nsh, nst, m;
    bit ntc, nerr;
    m = int'(bus.modulo);
    nq = mq; nsh = msh; nst = ms; ntc = 0; nerr = merr;
    if (ms == 0 || ms == 1) begin
      if (mq != msh) nerr = 1;
      if (ms == 1) begin
        if (bus.up) begin
          if (mq >= m) begin nq = 0; ntc = 1; end
          else nq = mq + 1;
        end else begin
          if (mq == 0) begin nq = m; ntc = 1; end
          else if (mq > m) nq = m;
          else nq = mq - 1;
        end
        nsh = nq;
      end
      if (bus.clear) begin nst = 3; mret = (ms == 1); nq = 0; end
      else if (bus.load) begin nst = 2; mret = (ms == 1); mload = int'(bus.load_val); end
      else if (bus.stop && ms == 1) nst = 0;
      else if (bus.start && ms == 0) nst = 1;
    end else begin
      nst = mret ? 1 : 0;
      if (ms == 2) begin nq = mload; nsh = mload; end
      else begin nq = 0; nsh = 0; nerr = 0; end
    end
    nq = nq ^ int'(inj);
    @(posedge clk);
    mq = nq; msh = nsh; ms = nst; mtc = ntc; merr = nerr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL rst_tc: got %b want 0", bus.tc); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    checks++; if (bus.bank_clr !== 1'b1) begin errors++; $display("FAIL rst_bank_clr: got %b want 1", bus.bank_clr); end
    checks++; if (bus.t_out !== 4'h0) begin errors++; $display("FAIL rst_t_out: got %h want 0", bus.t_out); end
    checks++; if (bq !== 4'h0) begin errors++; $display("FAIL rst_q: got %h want 0", bq); end
    reset_n = 1'b1;
    model_reset();
    tick();
    checks++; if (bus.bank_clr !== 1'b0) begin errors++; $display("FAIL rel_bank_clr: got %b want 0", bus.bank_clr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rel_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_up_mod5();
    int exp_q[7] = '{1, 2, 3, 4, 5, 0, 1};
    bit exp_tc[7] = '{0, 0, 0, 0, 0, 1, 0};
    bus.modulo = 4'd5; bus.up = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL up5_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (bq !== W'(exp_q[i])) begin errors++; $display("FAIL up5_q[%0d]: got %0d want %0d", i, bq, exp_q[i]); end
      checks++; if (bus.tc !== exp_tc[i]) begin errors++; $display("FAIL up5_tc[%0d]: got %b want %b", i, bus.tc, exp_tc[i]); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL up5_err[%0d]: got %b want 0", i, bus.err); end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bq !== W'(mq) || bus.tc !== mtc) begin errors++; $display("FAIL up5_run[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, bq, bus.tc, mq, mtc); end
    end
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL up5_stop: got %0d want 0", bus.state); end
  endtask

  task automatic test_down_mod9();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    tick();
    bus.modulo = 4'd9; bus.up = 1'b0; bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    checks++; if (bq !== 4'd9 || bus.tc !== 1'b1) begin errors++; $display("FAIL dn9_wrap: got q=%0d tc=%b want q=9 tc=1", bq, bus.tc); end
    for (int i = 0; i < 21; i++) begin
      tick();
      checks++; if (bq !== W'(mq) || bus.tc !== mtc) begin errors++; $display("FAIL dn9_run[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, bq, bus.tc, mq, mtc); end
      checks++; if (bq > 4'd9) begin errors++; $display("FAIL dn9_range[%0d]: got q=%0d want <=9", i, bq); end
    end
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
  endtask

  task automatic test_load_idle();
    bus.load = 1'b1; bus.load_val = 4'hA; tick(); bus.load = 1'b0;
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL ld_state: got %0d want 2", bus.state); end
    tick();
    checks++; if (bq !== 4'hA) begin errors++; $display("FAIL ld_q: got %h want a", bq); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.state !== 2'b00 || bq !== 4'hA || bus.t_out !== 4'h0) begin errors++; $display("FAIL ld_hold[%0d]: got st=%0d q=%h t=%h want st=0 q=a t=0", i, bus.state, bq, bus.t_out); end
    end
    bus.up = 1'b1; bus.modulo = 4'hF; bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    checks++; if (bq !== 4'hB) begin errors++; $display("FAIL ld_cnt1: got %h want b", bq); end
    tick();
    checks++; if (bq !== 4'hC || bus.err !== 1'b0) begin errors++; $display("FAIL ld_cnt2: got q=%h err=%b want q=c err=0", bq, bus.err); end
  endtask

  task automatic test_clear_wins();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); tick(); tick();
    checks++; if (bq !== 4'd3) begin errors++; $display("FAIL clr_pre: got %0d want 3", bq); end
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_val = 4'd7; tick();
    bus.clear = 1'b0; bus.load = 1'b0;
    checks++; if (bus.state !== 2'b11 || bus.bank_clr !== 1'b1 || bq !== 4'd0) begin errors++; $display("FAIL clr_win: got st=%0d clr=%b q=%0d want st=3 clr=1 q=0", bus.state, bus.bank_clr, bq); end
    tick();
    checks++; if (bus.state !== 2'b01 || bus.bank_clr !== 1'b0 || bq !== 4'd0) begin errors++; $display("FAIL clr_ret: got st=%0d clr=%b q=%0d want st=1 clr=0 q=0", bus.state, bus.bank_clr, bq); end
    tick();
    checks++; if (bq !== 4'd1) begin errors++; $display("FAIL clr_res1: got %0d want 1", bq); end
    tick();
    checks++; if (bq !== 4'd2) begin errors++; $display("FAIL clr_res2: got %0d want 2", bq); end
  endtask

  task automatic test_err();
    tick();
    inj = 4'b0100; tick(); inj = '0;
    checks++; if (bus.err !== 1'b0 || bq !== W'(mq)) begin errors++; $display("FAIL err_pre: got err=%b q=%0d want err=0 q=%0d", bus.err, bq, mq); end
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_rise: got %b want 1", bus.err); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.err !== 1'b1 || bq !== W'(mq)) begin errors++; $display("FAIL err_sticky[%0d]: got err=%b q=%0d want err=1 q=%0d", i, bus.err, bq, mq); end
    end
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    checks++; if (bus.err !== 1'b1 || bus.state !== 2'b11) begin errors++; $display("FAIL err_inclr: got err=%b st=%0d want err=1 st=3", bus.err, bus.state); end
    tick();
    checks++; if (bus.err !== 1'b0 || bus.state !== 2'b01) begin errors++; $display("FAIL err_cleared: got err=%b st=%0d want err=0 st=1", bus.err, bus.state); end
  endtask

  task automatic test_mod0();
    bus.modulo = 4'd0; bus.up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bus.up = 1'b0;
      tick();
      if (i > 0) begin
        checks++; if (bq !== 4'd0 || bus.tc !== 1'b1) begin errors++; $display("FAIL mod0[%0d]: got q=%0d tc=%b want q=0 tc=1", i, bq, bus.tc); end
      end
    end
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bus.load = 1'b1; bus.load_val = 4'd9; tick(); bus.load = 1'b0;
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL rml_state: got %0d want 2", bus.state); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'b00 || bus.bank_clr !== 1'b1 || bus.t_out !== 4'h0 || bq !== 4'h0) begin errors++; $display("FAIL rml_async: got st=%0d clr=%b t=%h q=%h want 0 1 0 0", bus.state, bus.bank_clr, bus.t_out, bq); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.state !== 2'b00 || bq !== 4'h0) begin errors++; $display("FAIL rml_hold[%0d]: got st=%0d q=%0d want st=0 q=0", i, bus.state, bq); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 11) == 0);
      bus.load  = ($urandom_range(0, 15) == 0);
      bus.clear = ($urandom_range(0, 23) == 0);
      bus.load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.up = ~bus.up;
      if ($urandom_range(0, 15) == 0) bus.modulo = W'($urandom_range(0, 15));
      tick();
      checks++; if (bq !== W'(mq) || bus.state !== 2'(ms) || bus.tc !== mtc || bus.err !== merr || bus.busy !== (ms == 1)) begin
        errors++; $display("FAIL rnd[%0d]: got q=%0d st=%0d tc=%b err=%b busy=%b want q=%0d st=%0d tc=%b err=%b", i, bq, bus.state, bus.tc, bus.err, bus.busy, mq, ms, mtc, merr);
      end
    end
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.up = 1; bus.load = 0; bus.load_val = '0;
    bus.clear = 0; bus.modulo = '0; inj = '0;
    test_reset();
    test_up_mod5();
    test_down_mod9();
    test_load_idle();
    test_clear_wins();
    test_err();
    test_mod0();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tff_bank_ctrl.md
Name: tff_bank_ctrl

Overview:
- Sequencer for a bank of WIDTH T flip-flops (active-high clear, toggle on rising edge when T=1).
- Drives the bank's per-bit T inputs and clear, and reads back its Q outputs, to make it a programmable modulo up/down counter with run/stop, parallel load and clear.
- Keeps a shadow count and flags any divergence between the bank and the expected value.
- Sits between software-visible control strobes and the TFF bank instance.

Parameters:
- WIDTH, 4, number of T flip-flops in the controlled bank (2..16).

Ports:
- clk  input  1  rising-edge clock, shared with the TFF bank.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle strobe: begin counting.
- stop  input  1  one-cycle strobe: halt counting.
- up  input  1  direction; 1=up, 0=down; sampled every RUN cycle.
- load  input  1  one-cycle strobe: load load_val into the bank.
- load_val  input  WIDTH  value to load.
- clear  input  1  one-cycle strobe: clear the bank to 0.
- modulo  input  WIDTH  terminal value M; the count range is 0..M.
- q_fb  input  WIDTH  Q outputs of the bank.
- t_out  output  WIDTH  T inputs to the bank.
- bank_clr  output  1  active-high clear to the bank.
- busy  output  1  high in RUN.
- tc  output  1  registered one-cycle terminal-count pulse.
- err  output  1  sticky shadow/bank mismatch flag.
- state  output  2  current FSM state.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State enters IDLE; shadow=0; tc=0; err=0.
  - t_out forced to 0; bank_clr=1 combinationally while reset_n is low.
- FSM states: IDLE=2'b00, RUN=2'b01, LOAD=2'b10, CLEAR=2'b11.
- Strobe priority in IDLE/RUN: clear > load > stop > start.
  - clear -> CLEAR.
  - load -> LOAD.
  - stop (RUN only) -> IDLE.
  - start (IDLE only) -> RUN.
  - start in RUN and stop in IDLE are ignored.
- CLEAR (one cycle):
  - bank_clr=1, t_out=0, shadow<=0.
  - Next state is the return state latched on entry: RUN if entered from RUN, else IDLE.
- LOAD (one cycle):
  - t_out = q_fb ^ load_val, so the bank equals load_val after the edge; shadow<=load_val.
  - Returns to the latched state (IDLE or RUN).
  - Strobes arriving in CLEAR or LOAD are dropped.
- IDLE: t_out=0, bank holds.
- RUN, up=1:
  - If q_fb >= modulo: t_out = q_fb (next value 0, wrap), tc<=1.
  - Else t_out[0]=1 and t_out[i] = AND of q_fb[i-1:0] (binary increment).
- RUN, down=0:
  - If q_fb == 0: t_out = modulo (next value M, wrap), tc<=1.
  - If q_fb > modulo: t_out = q_fb ^ modulo (snap to M), no tc.
  - Else t_out[0]=1 and t_out[i] = AND of ~q_fb[i-1:0] (binary decrement).
- Shadow:
  - Updates to the expected next value every RUN cycle.
  - Holds in IDLE.
- err:
  - Compare q_fb against shadow every cycle in IDLE and RUN.
  - Any mismatch sets err (sticky) until reset or a CLEAR state.
- t_out and bank_clr are combinational from state, q_fb, up and modulo. All other outputs are registered.
- busy = (state==RUN).
- modulo=0:
  - Up mode: the bank stays at 0 and tc pulses every RUN cycle.
  - Down mode: same behaviour.
- modulo is changed mid-run: it takes effect on the next cycle's compare.
- Latency: strobe in cycle n -> state change at edge n -> bank effect at edge n+1.
- reset_n asserted mid-LOAD or mid-CLEAR: immediate IDLE; the bank is cleared via bank_clr.

Test Plan:
- Reset low then high; start; up=1, modulo=5 -> q_fb sequence 0,1,2,3,4,5,0,1; tc high exactly one cycle after each 5->0 edge; busy=1; err=0.
- RUN up=0, modulo=9, from 0 -> 9,8,...,0,9; tc pulses after each 0->9 wrap; q_fb never exceeds 9.
- IDLE, load with load_val=4'hA, then start, up=1, modulo=4'hF -> bank reads 0xA; next counts 0xB, 0xC; returns to RUN only via start; shadow matches (err=0).
- RUN at count 3; assert clear and load in the same cycle -> CLEAR wins; bank_clr=1 for one cycle; q_fb=0; state returns to RUN; count resumes 1,2,...
- Force q_fb to a wrong value for one cycle (bench drives the bank flip) -> err rises next edge and stays high through subsequent counting; clear strobe -> err=0.
- Assert reset_n low asynchronously mid-LOAD (between clock edges) -> state=IDLE, bank_clr=1, t_out=0 immediately; after release, q_fb=0 and the bank holds until start.
